// File: rtl/spmv_pkg.sv
// Shared types for the SpMV memory arbiter: tag-table entry, request source, id width.
// Supplies fallback bus widths when the platform headers have not defined them.
`ifndef DCP_PADDR_MASK
`define DCP_PADDR_MASK 47:0
`endif
`ifndef DCP_NOC_RES_DATA_SIZE
`define DCP_NOC_RES_DATA_SIZE 64
`endif

package spmv_pkg;
  localparam int TRANSID_W = 6;

  typedef enum logic {
    SRC_VEC = 1'b0,
    SRC_MAT = 1'b1
  } src_e;

  typedef struct packed {
    logic                 valid;
    src_e                 src;
    logic [TRANSID_W-1:0] local_transid;
  } tag_entry_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/spmv_mem_arb_if.sv
// Bus bundle between the vector/matrix sources, the NoC and the arbiter.
// The arbiter takes the slave view; the surrounding environment takes the master view.
interface spmv_mem_arb_if;
  import spmv_pkg::*;

  logic                              vec_req_val;
  logic                              vec_req_rdy;
  logic [TRANSID_W-1:0]              vec_req_transid;
  logic [`DCP_PADDR_MASK]            vec_req_addr;
  logic                              mat_req_val;
  logic                              mat_req_rdy;
  logic [TRANSID_W-1:0]              mat_req_transid;
  logic [`DCP_PADDR_MASK]            mat_req_addr;
  logic                              noc_req_val;
  logic                              noc_req_rdy;
  logic [TRANSID_W-1:0]              noc_req_transid;
  logic [`DCP_PADDR_MASK]            noc_req_addr;
  logic                              noc_resp_val;
  logic [TRANSID_W-1:0]              noc_resp_transid;
  logic [`DCP_NOC_RES_DATA_SIZE-1:0] noc_resp_data;
  logic                              vec_resp_val;
  logic                              mat_resp_val;
  logic [TRANSID_W-1:0]              vec_resp_transid;
  logic [TRANSID_W-1:0]              mat_resp_transid;
  logic [`DCP_NOC_RES_DATA_SIZE-1:0] resp_data;
  logic                              busy;

  modport slave (
    input  vec_req_val, vec_req_transid, vec_req_addr,
    input  mat_req_val, mat_req_transid, mat_req_addr,
    input  noc_req_rdy, noc_resp_val, noc_resp_transid, noc_resp_data,
    output vec_req_rdy, mat_req_rdy, noc_req_val, noc_req_transid, noc_req_addr,
    output vec_resp_val, mat_resp_val, vec_resp_transid, mat_resp_transid, resp_data, busy
  );

  modport master (
    output vec_req_val, vec_req_transid, vec_req_addr,
    output mat_req_val, mat_req_transid, mat_req_addr,
    output noc_req_rdy, noc_resp_val, noc_resp_transid, noc_resp_data,
    input  vec_req_rdy, mat_req_rdy, noc_req_val, noc_req_transid, noc_req_addr,
    input  vec_resp_val, mat_resp_val, vec_resp_transid, mat_resp_transid, resp_data, busy
  );
endinterface

// File: rtl/spmv_tag_alloc.sv
// Free bitmap for NoC tags with a lowest-index-free encoder and a full flag.
// The encoder sees only the registered map, so a tag freed at an edge is offered from the next cycle.
module spmv_tag_alloc
  import spmv_pkg::*;
#(
  parameter int NUM_TAGS = 64,
  localparam int TAG_W = $clog2(NUM_TAGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                alloc_en,
  input  logic [TAG_W-1:0]    alloc_tag,
  input  logic                free_en,
  input  logic [TAG_W-1:0]    free_tag,
  output logic [NUM_TAGS-1:0] used,
  output logic [TAG_W-1:0]    lowest_free,
  output logic                full
);
  logic [NUM_TAGS-1:0] free_map;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      free_map <= '1;
    end else begin
      if (alloc_en) free_map[alloc_tag] <= 1'b0;
      if (free_en)  free_map[free_tag]  <= 1'b1;
    end
  end

  always_comb begin
    lowest_free = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (free_map[i]) lowest_free = TAG_W'(i);
    end
  end

  assign full = ~|free_map;
  assign used = ~free_map;
endmodule

// File: rtl/spmv_mem_arb.sv
// Round-robin arbiter merging vector-prefetch and matrix-stream reads onto one NoC port with tag remapping.
// Optional 32-bit saturating performance counters are built when SPMV_MEM_ARB_PERF_EN is defined.
module spmv_mem_arb
  import spmv_pkg::*;
#(
  parameter int NUM_TAGS   = 64,
  parameter int RR_EN_INIT = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spmv_mem_arb_if.slave        bus
`ifdef SPMV_MEM_ARB_PERF_EN
  ,
  output logic [31:0]          perf_vec_reqs,
  output logic [31:0]          perf_mat_reqs,
  output logic [31:0]          perf_tag_stall
`endif
);
  localparam int TAG_W    = $clog2(NUM_TAGS);
  localparam int MAX_TAGS = 1 << TRANSID_W;

  src_e                 prio;
  logic [NUM_TAGS-1:0]  used;
  logic [MAX_TAGS-1:0]  used_ext;
  logic [TAG_W-1:0]     free_tag;
  logic [TAG_W-1:0]     resp_idx;
  logic                 full;
  logic                 vec_elig;
  logic                 mat_elig;
  logic                 grant_mat;
  logic                 hs;
  logic                 resp_hit;
  tag_entry_t           resp_entry;
  src_e                 src_mem [NUM_TAGS];
  logic [TRANSID_W-1:0] id_mem  [NUM_TAGS];

  spmv_tag_alloc #(.NUM_TAGS(NUM_TAGS)) u_alloc (
    .clk         (clk),
    .rst_n       (rst_n),
    .alloc_en    (hs),
    .alloc_tag   (free_tag),
    .free_en     (resp_hit),
    .free_tag    (resp_idx),
    .used        (used),
    .lowest_free (free_tag),
    .full        (full)
  );

  // Request side: purely combinational grant onto the NoC
  assign vec_elig  = bus.vec_req_val && !full;
  assign mat_elig  = bus.mat_req_val && !full;
  assign grant_mat = mat_elig && (!vec_elig || prio == SRC_MAT);
  assign hs        = bus.noc_req_val && bus.noc_req_rdy;

  assign bus.noc_req_val     = vec_elig || mat_elig;
  assign bus.noc_req_addr    = grant_mat ? bus.mat_req_addr : bus.vec_req_addr;
  assign bus.noc_req_transid = TRANSID_W'(free_tag);
  assign bus.vec_req_rdy     = vec_elig && !grant_mat && bus.noc_req_rdy;
  assign bus.mat_req_rdy     = grant_mat && bus.noc_req_rdy;
  assign bus.busy            = |used;

  always_ff @(posedge clk) begin
    if (hs) begin
      src_mem[free_tag] <= grant_mat ? SRC_MAT : SRC_VEC;
      id_mem[free_tag]  <= grant_mat ? bus.mat_req_transid : bus.vec_req_transid;
    end
  end

  // Response lookup; tags outside the table read as not valid
  assign used_ext   = MAX_TAGS'(used);
  assign resp_idx   = bus.noc_resp_transid[TAG_W-1:0];
  assign resp_entry = '{valid:         used_ext[bus.noc_resp_transid],
                        src:           src_mem[resp_idx],
                        local_transid: id_mem[resp_idx]};
  assign resp_hit   = bus.noc_resp_val && resp_entry.valid;

  // Registered response stage and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio                 <= (RR_EN_INIT != 0) ? SRC_MAT : SRC_VEC;
      bus.vec_resp_val     <= 1'b0;
      bus.mat_resp_val     <= 1'b0;
      bus.vec_resp_transid <= '0;
      bus.mat_resp_transid <= '0;
      bus.resp_data        <= '0;
    end else begin
      if (hs) prio <= (prio == SRC_VEC) ? SRC_MAT : SRC_VEC;
      bus.vec_resp_val <= resp_hit && resp_entry.src == SRC_VEC;
      bus.mat_resp_val <= resp_hit && resp_entry.src == SRC_MAT;
      if (resp_hit) begin
        bus.resp_data <= bus.noc_resp_data;
        if (resp_entry.src == SRC_VEC) bus.vec_resp_transid <= resp_entry.local_transid;
        else                           bus.mat_resp_transid <= resp_entry.local_transid;
      end
    end
  end

`ifdef SPMV_MEM_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_vec_reqs  <= '0;
      perf_mat_reqs  <= '0;
      perf_tag_stall <= '0;
    end else begin
      if (bus.vec_req_val && bus.vec_req_rdy) perf_vec_reqs <= sat_inc(perf_vec_reqs);
      if (bus.mat_req_val && bus.mat_req_rdy) perf_mat_reqs <= sat_inc(perf_mat_reqs);
      if ((bus.vec_req_val || bus.mat_req_val) && full) perf_tag_stall <= sat_inc(perf_tag_stall);
    end
  end
`endif
endmodule

// File: tb/tb_spmv_mem_arb.sv
// Bench for spmv_mem_arb: directed scenarios plus random traffic against an outstanding-tag model,
// with a queue-based scoreboard drained by an independent response monitor.
`timescale 1ns/1ps
module tb_spmv_mem_arb;
  import spmv_pkg::*;

  localparam int NT = 64;
  typedef logic [`DCP_PADDR_MASK] addr_t;
  typedef logic [`DCP_NOC_RES_DATA_SIZE-1:0] data_t;

  typedef struct {
    bit                   src;
    logic [TRANSID_W-1:0] id;
    data_t                data;
    int                   due;
  } exp_t;

  logic clk;
  logic rst_n;
  spmv_mem_arb_if bus();
`ifdef SPMV_MEM_ARB_PERF_EN
  logic [31:0] perf_vec_reqs, perf_mat_reqs, perf_tag_stall;
`endif

  spmv_mem_arb #(.NUM_TAGS(NT), .RR_EN_INIT(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef SPMV_MEM_ARB_PERF_EN
    ,
    .perf_vec_reqs  (perf_vec_reqs),
    .perf_mat_reqs  (perf_mat_reqs),
    .perf_tag_stall (perf_tag_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  // Reference: which tags are outstanding, who owns them, and whose turn it is
  bit                   m_valid [NT];
  bit                   m_src   [NT];
  logic [TRANSID_W-1:0] m_id    [NT];
  bit                   m_prio;
  bit                   g_hs;
  bit                   g_src;
  int                   g_tag;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit model_busy();
    bit b = 1'b0;
    for (int i = 0; i < NT; i++) b |= m_valid[i];
    return b;
  endfunction

  task automatic drive_cycle(input bit vv, input bit mv, input addr_t va, input addr_t ma,
                             input logic [5:0] vid, input logic [5:0] mid, input bit nrdy,
                             input bit rv, input logic [5:0] rtag, input data_t rdata);
    int   lo;
    bit   ve, me, wm;
    exp_t e;
    @(negedge clk);
    bus.vec_req_val      = vv;
    bus.mat_req_val      = mv;
    bus.vec_req_addr     = va;
    bus.mat_req_addr     = ma;
    bus.vec_req_transid  = vid;
    bus.mat_req_transid  = mid;
    bus.noc_req_rdy      = nrdy;
    bus.noc_resp_val     = rv;
    bus.noc_resp_transid = rtag;
    bus.noc_resp_data    = rdata;
    #1;
    lo = -1;
    for (int i = 0; i < NT; i++) if (!m_valid[i] && lo < 0) lo = i;
    ve = vv && (lo >= 0);
    me = mv && (lo >= 0);
    wm = me && (!ve || m_prio);
    chk("noc_req_val", 64'(bus.noc_req_val), 64'(ve || me));
    chk("vec_req_rdy", 64'(bus.vec_req_rdy), 64'(ve && !wm && nrdy));
    chk("mat_req_rdy", 64'(bus.mat_req_rdy), 64'(wm && nrdy));
    chk("busy", 64'(bus.busy), 64'(model_busy()));
    if (ve || me) begin
      chk("noc_req_transid", 64'(bus.noc_req_transid), 64'(lo));
      chk("noc_req_addr", 64'(bus.noc_req_addr), 64'(wm ? ma : va));
    end
    if (rv && m_valid[rtag]) begin
      e.src  = m_src[rtag];
      e.id   = m_id[rtag];
      e.data = rdata;
      e.due  = cyc + 1;
      sb.push_back(e);
      m_valid[rtag] = 1'b0;
    end
    g_hs = (ve || me) && nrdy;
    if (g_hs) begin
      g_tag       = lo;
      g_src       = wm;
      m_valid[lo] = 1'b1;
      m_src[lo]   = wm;
      m_id[lo]    = wm ? mid : vid;
      m_prio      = !m_prio;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(0, 0, '0, '0, '0, '0, 0, 0, '0, '0);
  endtask

  task automatic vec_req(input logic [5:0] vid);
    drive_cycle(1, 0, addr_t'({$urandom, $urandom}), '0, vid, '0, 1, 0, '0, '0);
  endtask

  task automatic respond(input logic [5:0] tag);
    drive_cycle(0, 0, '0, '0, '0, '0, 0, 1, tag, data_t'({$urandom, $urandom}));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.vec_req_val  = 1'b0;
    bus.mat_req_val  = 1'b0;
    bus.noc_resp_val = 1'b0;
    bus.noc_req_rdy  = 1'b0;
    #1;
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_vec_resp_val", 64'(bus.vec_resp_val), 64'(0));
    chk("rst_mat_resp_val", 64'(bus.mat_resp_val), 64'(0));
    chk("rst_vec_resp_transid", 64'(bus.vec_resp_transid), 64'(0));
    chk("rst_mat_resp_transid", 64'(bus.mat_resp_transid), 64'(0));
    chk("rst_resp_data", 64'(bus.resp_data), 64'(0));
    for (int i = 0; i < NT; i++) m_valid[i] = 1'b0;
    m_prio = 1'b0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Response monitor: every pulse must match the head of the scoreboard on time
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (bus.vec_resp_val || bus.mat_resp_val) begin
        chk("resp_onehot", 64'(bus.vec_resp_val & bus.mat_resp_val), 64'(0));
        if (sb.size() == 0) begin
          chk("resp_unexpected", 64'(1), 64'(bus.vec_resp_val & bus.mat_resp_val));
        end else begin
          e = sb.pop_front();
          chk("resp_src", 64'(bus.mat_resp_val), 64'(e.src));
          chk("resp_transid", 64'(e.src ? bus.mat_resp_transid : bus.vec_resp_transid), 64'(e.id));
          chk("resp_data", 64'(bus.resp_data), 64'(e.data));
          chk("resp_cycle", 64'(cyc), 64'(e.due));
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        chk("resp_missing", 64'(bus.vec_resp_val | bus.mat_resp_val), 64'(1));
        sb.delete(0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, t;
    bit found;
    rst_n = 1'b0;
    bus.vec_req_val = 0; bus.mat_req_val = 0; bus.noc_req_rdy = 0; bus.noc_resp_val = 0;
    bus.vec_req_addr = '0; bus.mat_req_addr = '0; bus.vec_req_transid = '0;
    bus.mat_req_transid = '0; bus.noc_resp_transid = '0; bus.noc_resp_data = '0;
    repeat (2) @(negedge clk);
    do_reset();

    // Single vector request and its response
    drive_cycle(1, 0, addr_t'(32'h1000), '0, 6'd5, '0, 1, 0, '0, '0);
    chk("single_hs", 64'(g_hs), 64'(1));
    chk("single_tag", 64'(g_tag), 64'(0));
    chk("single_src", 64'(g_src), 64'(0));
    respond(6'd0);
    idle(2);

    // Contention alternates starting from the vector source
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1, 1, addr_t'({$urandom, $urandom}), addr_t'({$urandom, $urandom}),
                  6'(i), 6'(10 + i), 1, 0, '0, '0);
      chk("rr_src", 64'(g_src), 64'(i % 2));
      chk("rr_tag", 64'(g_tag), 64'(i));
    end

    // Fill the table, then recycle tag 17
    for (int i = 4; i < NT; i++) vec_req(6'($urandom));
    drive_cycle(1, 1, '0, '0, '0, '0, 1, 0, '0, '0);
    chk("full_no_grant", 64'(g_hs), 64'(0));
    respond(6'd17);
    vec_req(6'd42);
    chk("refill_tag17", 64'(g_tag), 64'(17));

    // Response and request in the same cycle on a full table
    drive_cycle(1, 0, '0, '0, 6'd7, '0, 1, 1, 6'd3, data_t'({$urandom, $urandom}));
    chk("same_cycle_no_grant", 64'(g_hs), 64'(0));
    vec_req(6'd8);
    chk("next_cycle_hs", 64'(g_hs), 64'(1));
    chk("next_cycle_tag3", 64'(g_tag), 64'(3));

    // Spurious response to a freed tag
    respond(6'd9);
    idle(2);
    respond(6'd9);
    idle(2);
    chk("spurious_busy", 64'(bus.busy), 64'(1));

    // Reset with traffic outstanding, then a late response
    do_reset();
    for (int i = 0; i < 10; i++) vec_req(6'(i));
    idle(1);
    do_reset();
    respond(6'd2);
    idle(2);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      k = $urandom_range(NT - 1);
      found = 1'b0;
      t = 0;
      for (int j = 0; j < NT; j++) begin
        if (!found && m_valid[(k + j) % NT]) begin
          found = 1'b1;
          t = (k + j) % NT;
        end
      end
      if (!found || $urandom_range(3) == 0) t = $urandom_range(NT - 1);
      drive_cycle($urandom_range(1), $urandom_range(1),
                  addr_t'({$urandom, $urandom}), addr_t'({$urandom, $urandom}),
                  6'($urandom), 6'($urandom), $urandom_range(3) != 0,
                  $urandom_range(4) < 2, 6'(t), data_t'({$urandom, $urandom}));
    end
    idle(3);
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
